// File: rtl/fork_join_pkg.sv
// rtl/fork_join_pkg.sv - shared types and defaults for the fork/join timer
package fork_join_pkg;

    localparam int NUM_THREADS_DEF = 3;
    localparam int CNT_W_DEF       = 8;

    typedef enum logic [1:0] {
        JOIN_ALL  = 2'd0,
        JOIN_ANY  = 2'd1,
        JOIN_NONE = 2'd2
    } join_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fj_state_e;

    // The reserved encoding behaves as JOIN_ALL.
    function automatic join_mode_e decode_mode(input logic [1:0] m);
        return (m == 2'd3) ? JOIN_ALL : join_mode_e'(m);
    endfunction

endpackage

// File: rtl/thread_counter.sv
// rtl/thread_counter.sv - one posedge down-counter with sticky done and fin pulse
module thread_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             kill,
    output logic [CNT_W-1:0] cnt,
    output logic             done,
    output logic             fin,
    output logic             done_next
);

    logic fin_next;

    // done_next is exported so the parent can judge the join on post-edge flags.
    always_comb begin
        done_next = done;
        fin_next  = 1'b0;
        if (load) begin
            done_next = (load_val == '0);
            fin_next  = (load_val == '0);
        end else if (!kill && cnt == CNT_W'(1)) begin
            done_next = 1'b1;
            fin_next  = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            done <= 1'b0;
            fin  <= 1'b0;
        end else begin
            done <= done_next;
            fin  <= fin_next;
            if (load)
                cnt <= load_val;
            else if (kill)
                cnt <= '0;
            else if (cnt != '0)
                cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/fork_join_timer.sv
// rtl/fork_join_timer.sv - parallel delay counters with all/any/none join and kill
module fork_join_timer
    import fork_join_pkg::*;
#(
    parameter int NUM_THREADS = NUM_THREADS_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                         clock,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic [NUM_THREADS*CNT_W-1:0] delay,
    input  logic                         kill,
    output logic                         busy,
    output logic [NUM_THREADS-1:0]       thread_done,
    output logic [NUM_THREADS-1:0]       thread_fin,
    output logic                         join_done,
    output logic                         killed
);

    fj_state_e              state, state_nxt;
    join_mode_e             mode_q;
    logic                   joined;
    logic [CNT_W-1:0]       cnt [NUM_THREADS];
    logic [NUM_THREADS-1:0] done_next;
    logic [NUM_THREADS-1:0] run_left;
    logic [NUM_THREADS-1:0] lane_nz;
    logic                   accept, final_edge, kill_eff, join_now;

    function automatic logic join_met(input join_mode_e m, input logic [NUM_THREADS-1:0] d);
        case (m)
            JOIN_ANY:  return |d;
            JOIN_NONE: return 1'b1;
            default:   return &d;
        endcase
    endfunction

    assign accept     = (state == IDLE) && start;
    // Final edge: every counter still running is about to hit zero.
    assign final_edge = (state == RUN) && (run_left == '0);
    assign kill_eff   = (state == RUN) && kill && !final_edge;
    assign busy       = (state == RUN);

    for (genvar i = 0; i < NUM_THREADS; i++) begin : g_thr
        thread_counter #(.CNT_W(CNT_W)) u_cnt (
            .clock     (clock),
            .rst_n     (rst_n),
            .load      (accept),
            .load_val  (delay[i*CNT_W +: CNT_W]),
            .kill      (kill_eff),
            .cnt       (cnt[i]),
            .done      (thread_done[i]),
            .fin       (thread_fin[i]),
            .done_next (done_next[i])
        );
        assign run_left[i] = (cnt[i] > CNT_W'(1));
        assign lane_nz[i]  = (delay[i*CNT_W +: CNT_W] != '0);
    end

    always_comb begin
        state_nxt = state;
        join_now  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    join_now = join_met(decode_mode(mode), done_next);
                    if (lane_nz != '0)
                        state_nxt = RUN;
                end
            end
            RUN: begin
                join_now = !kill_eff && !joined && join_met(mode_q, done_next);
                if (final_edge || kill_eff)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_q    <= JOIN_ALL;
            joined    <= 1'b0;
            join_done <= 1'b0;
            killed    <= 1'b0;
        end else begin
            state     <= state_nxt;
            join_done <= join_now;
            killed    <= kill_eff;
            if (accept) begin
                mode_q <= decode_mode(mode);
                joined <= join_now;
            end else begin
                joined <= joined | join_now;
            end
        end
    end

endmodule

// File: tb/tb_fork_join_timer.sv
// tb/tb_fork_join_timer.sv - scoreboard bench for fork_join_timer
module tb_fork_join_timer;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [23:0] delay;
    logic        kill;
    logic        busy;
    logic [2:0]  thread_done;
    logic [2:0]  thread_fin;
    logic        join_done;
    logic        killed;

    fork_join_timer #(.NUM_THREADS(3), .CNT_W(8)) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .start       (start),
        .mode        (mode),
        .delay       (delay),
        .kill        (kill),
        .busy        (busy),
        .thread_done (thread_done),
        .thread_fin  (thread_fin),
        .join_done   (join_done),
        .killed      (killed)
    );

    always #5 clock = ~clock;

    int cyc  = 0;
    int base = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [2:0] fin;
        logic       jn;
        logic       kl;
        logic [2:0] dn;
        logic       bs;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - base);
        end
    endtask

    task automatic push(input int c, input logic [2:0] f, input logic j, input logic k,
                        input logic [2:0] d, input logic b);
        exp_q.push_back('{c, f, j, k, d, b});
    endtask

    task automatic launch(input logic [1:0] m, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2);
        mode  = m;
        delay = {d2, d1, d0};
        start = 1'b1;
        base  = cyc + 1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic at_rel(input int k);
        while (cyc - base < k) begin
            @(posedge clock); #1;
        end
    endtask

    // Monitor: every output pulse must match the next queued expectation.
    always @(negedge clock) begin
        ev_t e;
        if (rst_n === 1'b1 && (thread_fin != 3'b000 || join_done || killed)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {27'd0, thread_fin, join_done, killed}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ev_cycle",  cyc - base,  e.c);
                chk("ev_fin",    thread_fin,  e.fin);
                chk("ev_join",   join_done,   e.jn);
                chk("ev_killed", killed,      e.kl);
                chk("ev_done",   thread_done, e.dn);
                chk("ev_busy",   busy,        e.bs);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        kill  = 1'b0;
        mode  = 2'd0;
        delay = '0;
        #12;
        chk("reset_outputs", {busy, thread_done, thread_fin, join_done, killed}, 32'd0);
        @(posedge clock); #1;
        rst_n = 1'b1;
        @(posedge clock); #1;

        // ALL {10,5,30}
        push(5,  3'b010, 1'b0, 1'b0, 3'b010, 1'b1);
        push(10, 3'b001, 1'b0, 1'b0, 3'b011, 1'b1);
        push(30, 3'b100, 1'b1, 1'b0, 3'b111, 1'b0);
        launch(2'd0, 8'd10, 8'd5, 8'd30);
        chk("all_busy_c0", busy, 1);
        at_rel(29);
        chk("all_busy_c29", busy, 1);
        at_rel(34);
        chk("all_drain", exp_q.size(), 0);

        // ANY {10,5,30}
        push(5,  3'b010, 1'b1, 1'b0, 3'b010, 1'b1);
        push(10, 3'b001, 1'b0, 1'b0, 3'b011, 1'b1);
        push(30, 3'b100, 1'b0, 1'b0, 3'b111, 1'b0);
        launch(2'd1, 8'd10, 8'd5, 8'd30);
        at_rel(29);
        chk("any_busy_c29", busy, 1);
        at_rel(34);
        chk("any_drain", exp_q.size(), 0);

        // NONE {3,0,7}
        push(0, 3'b010, 1'b1, 1'b0, 3'b010, 1'b1);
        push(3, 3'b001, 1'b0, 1'b0, 3'b011, 1'b1);
        push(7, 3'b100, 1'b0, 1'b0, 3'b111, 1'b0);
        launch(2'd2, 8'd3, 8'd0, 8'd7);
        at_rel(10);
        chk("none_drain", exp_q.size(), 0);

        // ALL {10,5,30} killed in cycle 12
        push(5,  3'b010, 1'b0, 1'b0, 3'b010, 1'b1);
        push(10, 3'b001, 1'b0, 1'b0, 3'b011, 1'b1);
        push(13, 3'b000, 1'b0, 1'b1, 3'b011, 1'b0);
        launch(2'd0, 8'd10, 8'd5, 8'd30);
        at_rel(12);
        kill = 1'b1;
        at_rel(13);
        kill = 1'b0;
        chk("kill_done_c13", thread_done, 3'b011);
        at_rel(40);
        chk("kill_busy_c40", busy, 0);
        chk("kill_drain", exp_q.size(), 0);

        // {4,4,4}: restart ignored, kill on completion edge loses
        push(4, 3'b111, 1'b1, 1'b0, 3'b111, 1'b0);
        launch(2'd0, 8'd4, 8'd4, 8'd4);
        at_rel(2);
        start = 1'b1;
        delay = {3{8'd1}};
        at_rel(3);
        start = 1'b0;
        kill  = 1'b1;
        at_rel(4);
        kill = 1'b0;
        at_rel(8);
        chk("coll_drain", exp_q.size(), 0);

        // reserved mode acts as ALL, {1,2,0}
        push(0, 3'b100, 1'b0, 1'b0, 3'b100, 1'b1);
        push(1, 3'b001, 1'b0, 1'b0, 3'b101, 1'b1);
        push(2, 3'b010, 1'b1, 1'b0, 3'b111, 1'b0);
        launch(2'd3, 8'd1, 8'd2, 8'd0);
        at_rel(5);
        chk("rsv_drain", exp_q.size(), 0);

        // all delays zero, ANY: never busy
        push(0, 3'b111, 1'b1, 1'b0, 3'b111, 1'b0);
        launch(2'd1, 8'd0, 8'd0, 8'd0);
        chk("zero_busy_c0", busy, 0);
        at_rel(4);
        chk("zero_drain", exp_q.size(), 0);

        // reset dropped in cycle 6 of an ALL run
        push(5, 3'b010, 1'b0, 1'b0, 3'b010, 1'b1);
        launch(2'd0, 8'd10, 8'd5, 8'd30);
        at_rel(6);
        rst_n = 1'b0;
        #2;
        chk("rst_mid_outputs", {busy, thread_done, thread_fin, join_done, killed}, 32'd0);
        @(posedge clock); @(posedge clock); #1;
        rst_n = 1'b1;
        at_rel(50);
        chk("rst_no_events", exp_q.size(), 0);

        // fresh start with kill alongside start in IDLE
        push(1, 3'b010, 1'b1, 1'b0, 3'b010, 1'b1);
        push(2, 3'b001, 1'b0, 1'b0, 3'b011, 1'b1);
        push(3, 3'b100, 1'b0, 1'b0, 3'b111, 1'b0);
        kill = 1'b1;
        launch(2'd1, 8'd2, 8'd1, 8'd3);
        kill = 1'b0;
        chk("fresh_busy_c0", busy, 1);
        at_rel(6);
        chk("fresh_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fork_join_timer.md
# fork_join_timer

Hardware counterpart of the testbench fork/join pattern. The testbench side launches parallel threads and waits on them. This block sits on the other end and answers them. It runs NUM_THREADS independent posedge down-counters from one start pulse, reports each thread's completion, and raises a single join indication according to a selectable join policy: all, any, or none. Its output synchronises stimulus sequencers, and it models thread-completion behaviour in synthesizable form.

## Interface
- NUM_THREADS, 3, number of parallel counters
- CNT_W, 8, width of each delay value
- clock  in  1  single clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  launch pulse; sampled only in IDLE
- mode  in  2  join policy, sampled with start: 0 JOIN_ALL, 1 JOIN_ANY, 2 JOIN_NONE, 3 reserved (treated as JOIN_ALL)
- delay  in  NUM_THREADS*CNT_W  packed per-thread posedge counts; thread i at bits [i*CNT_W +: CNT_W]; sampled with start
- kill  in  1  disable-fork; aborts all running threads
- busy  out  1  high while any thread is still counting
- thread_done  out  NUM_THREADS  sticky per-thread completion; cleared on the next accepted start
- thread_fin  out  NUM_THREADS  one-cycle pulse in the cycle thread_done[i] rises
- join_done  out  1  one-cycle pulse when the join condition is first met
- killed  out  1  one-cycle pulse after kill aborts a run

## Operation
- Cycle numbering: cycle 0 is the state visible after the posedge that samples start; cycle k is k posedges later.
- FSM states are IDLE and RUN.
- IDLE -> RUN on start. On that edge:
  - load cnt[i] = delay[i]
  - clear thread_done
  - latch mode
- A thread with delay 0 completes at the start edge: thread_done[i] and thread_fin[i] are high in cycle 0.
- In RUN, each posedge decrements every nonzero cnt[i].
  - When cnt[i] goes 1 -> 0, thread_done[i] sets and thread_fin[i] pulses.
  - Thread i with delay D therefore completes in cycle D.
- Join condition, evaluated on the post-edge done flags:
  - ALL: every thread_done is set.
  - ANY: at least one thread_done is set.
  - NONE: true in cycle 0.
- join_done pulses exactly once per run. Threads that are still counting continue after join_done in ANY and NONE modes.
- RUN -> IDLE on the edge where the last thread completes. busy is low from that cycle onward.
- If every delay is 0, the block returns to IDLE immediately and busy is never seen high. thread_done, thread_fin and join_done still appear in cycle 0.
- kill in RUN:
  - Next edge: all cnt zeroed, go to IDLE, killed pulses.
  - Unfinished threads keep thread_done = 0.
  - join_done is not issued if it has not already fired.
- kill in IDLE is ignored.
- kill and the final completion on the same edge: completion wins. thread_done and join_done assert, and killed does not pulse.
- start while in RUN is ignored. There is no queuing.
- start and kill together in IDLE: start is accepted.

## Timing
- Reset values, asserted asynchronously on rst_n low:
  - state IDLE
  - all cnt 0
  - busy 0, thread_done 0, thread_fin 0, join_done 0, killed 0
- Reset mid-run abandons the run immediately. No pulses are emitted.
- All outputs are registered; there is no combinational input-to-output path.
- Latency:
  - start to busy: 1 edge.
  - Thread i completion: delay[i] edges after the start edge.
- Maximum delay is 2^CNT_W - 1. There is no wrap-around: a counter at 0 holds.

## Structure
- Package fork_join_pkg holds:
  - typedef enum join_mode_e {JOIN_ALL, JOIN_ANY, JOIN_NONE}
  - typedef enum fj_state_e {IDLE, RUN}
  - localparam defaults for NUM_THREADS and CNT_W
- Sub-module thread_counter, one instance per thread via generate:
  - Inputs: load, load value, kill.
  - Outputs: done (sticky) and fin (pulse).
- The top level holds the FSM, the latched mode, and the join/killed logic.

## Test plan
- ALL, delays {10,5,30}: thread_fin[1] in cycle 5, thread_fin[0] in cycle 10, thread_fin[2] and join_done in cycle 30; busy falls in cycle 30.
- ANY, delays {10,5,30}: join_done in cycle 5 only; thread_fin pulses at 5, 10 and 30; busy high through cycle 29.
- NONE, delays {3,0,7}: join_done and thread_fin[1] in cycle 0; busy stays high until cycle 7.
- ALL, delays {10,5,30}, kill in cycle 12: killed pulses in cycle 13; thread_done = 3'b011; no join_done; busy falls in cycle 13.
- Collision case, delays {4,4,4}: start repeated in cycle 2 is ignored. kill asserted in cycle 3 is sampled on the completion edge, so join_done fires in cycle 4 with no killed pulse.
- rst_n dropped in cycle 6 of a {10,5,30} ALL run: all outputs go to 0 asynchronously. No join_done is seen after rst_n releases. A fresh start then runs normally.
